// File: rtl/pulse_transmitter_pkg.sv
// Shared types and constants for the pulse transmitter sequencer: FSM states,
// symbol encodings and the duration-table slicing helper.
package pulse_transmitter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   // Bit 1 of a symbol is the transmit level; bit 0 only selects a duration.
   localparam logic [1:0] LOW_A  = 2'd0;
   localparam logic [1:0] LOW_B  = 2'd1;
   localparam logic [1:0] HIGH_A = 2'd2;
   localparam logic [1:0] HIGH_B = 2'd3;

   // LSB position of the duration entry for symbol sym in the packed table.
   function automatic int unsigned dur_lsb(input logic [1:0] sym, input int unsigned width);
      return 32'(sym) * width;
   endfunction

endpackage

// File: rtl/pulse_transmitter_rising_edge_detector.sv
// Registered rising-edge detector: o_rise is high in the cycle where i_level
// is high and was low in the previous cycle.
module pulse_transmitter_rising_edge_detector (
   input  logic clk,
   input  logic rst_n,
   input  logic i_level,
   output logic o_rise
);

   logic r_level_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level_q <= 1'b0;
      end else begin
         r_level_q <= i_level;
      end
   end

   assign o_rise = i_level & ~r_level_q;

endmodule

// File: rtl/pulse_transmitter_sequencer.sv
// Program sequencer: walks a symbol window with one-symbol prefetch, maps each
// symbol to a timer duration and reloads the one-shot timer back-to-back.
module pulse_transmitter_sequencer
   import pulse_transmitter_pkg::*;
#(
   parameter int PC_WIDTH   = 7,
   parameter int DUR_WIDTH  = 8,
   parameter int LOOP_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   loop_en,
   input  logic [LOOP_WIDTH-1:0]  loop_count,
   input  logic [PC_WIDTH-1:0]    prog_start,
   input  logic [PC_WIDTH-1:0]    prog_end,
   input  logic [4*DUR_WIDTH-1:0] dur_table,
   output logic [PC_WIDTH-1:0]    sym_addr,
   input  logic [1:0]             sym_data,
   output logic                   tim_trig,
   output logic [DUR_WIDTH-1:0]   tim_duration,
   input  logic                   tim_done,
   output logic                   tx_level,
   output logic                   tx_valid,
   output logic                   busy,
   output logic                   done_pulse,
   output logic                   loop_pulse
);

   state_t                r_state;
   logic [PC_WIDTH-1:0]   r_pc;
   logic                  r_pf_level;
   logic [DUR_WIDTH-1:0]  r_pf_dur;
   logic                  r_pf_valid;
   logic                  r_pf_last;
   logic [LOOP_WIDTH-1:0] r_loop_rem;
   logic                  r_tx_level;
   logic                  r_tx_valid;

   logic                  w_start_edge;
   logic                  w_idle;
   logic                  w_launch;
   logic                  w_abort;
   logic                  w_issue;
   logic                  w_finish;
   logic                  w_fetch;
   logic [PC_WIDTH-1:0]   w_fetch_pc;
   logic [LOOP_WIDTH-1:0] w_loop_rem_cur;
   logic                  w_at_end;
   logic                  w_last_hit;
   logic                  w_wrap;
   logic [DUR_WIDTH-1:0]  w_dur_arr [4];
   logic [DUR_WIDTH-1:0]  w_sym_dur;

   pulse_transmitter_rising_edge_detector u_start_edge (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_level (start),
      .o_rise  (w_start_edge)
   );

   for (genvar k = 0; k < 4; k++) begin : g_dur
      assign w_dur_arr[k] = dur_table[dur_lsb(2'(k), DUR_WIDTH) +: DUR_WIDTH];
   end
   assign w_sym_dur = w_dur_arr[sym_data];

   // Timer handshake: tim_trig is a single-cycle load strobe carrying
   // tim_duration; the timer answers with a single-cycle tim_done. A prefetched
   // symbol is issued in the very tim_done cycle, so consecutive symbols abut.
   assign w_idle   = (r_state == IDLE);
   assign w_launch = w_idle && w_start_edge;
   assign w_abort  = !w_idle && !start;
   assign w_issue  = !w_abort && ((r_state == ISSUE) ||
                                  ((r_state == WAIT) && tim_done && r_pf_valid));
   assign w_finish = !w_abort && (r_state == WAIT) && tim_done && !r_pf_valid;
   assign w_fetch  = w_launch || (w_issue && !r_pf_last);

   // In IDLE the first fetch happens before pc and loop_rem are loaded.
   assign w_fetch_pc     = w_idle ? prog_start : r_pc;
   assign w_loop_rem_cur = w_idle ? loop_count : r_loop_rem;
   assign w_at_end       = (w_fetch_pc == prog_end);
   assign w_last_hit     = w_at_end &&
                           (!loop_en || ((loop_count != '0) && (w_loop_rem_cur == '0)));
   assign w_wrap         = w_fetch && w_at_end && !w_last_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_pc       <= '0;
         r_pf_level <= 1'b0;
         r_pf_dur   <= '0;
         r_pf_valid <= 1'b0;
         r_pf_last  <= 1'b0;
         r_loop_rem <= '0;
         r_tx_level <= 1'b0;
         r_tx_valid <= 1'b0;
      end else begin
         if (w_launch) begin
            r_loop_rem <= loop_count;
         end

         if (w_fetch) begin
            r_pf_level <= sym_data[1];
            r_pf_dur   <= w_sym_dur;
            r_pf_valid <= 1'b1;
            r_pf_last  <= w_last_hit;
            if (!w_at_end) begin
               r_pc <= w_fetch_pc + PC_WIDTH'(1);
            end else if (w_wrap) begin
               r_pc <= prog_start;
               if (loop_count != '0) begin
                  r_loop_rem <= w_loop_rem_cur - LOOP_WIDTH'(1);
               end
            end else begin
               r_pc <= w_fetch_pc;
            end
         end else if (w_issue) begin
            r_pf_valid <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (w_launch) begin
                  r_state <= ISSUE;
               end
            end
            ISSUE, WAIT: begin
               if (w_abort) begin
                  r_state    <= IDLE;
                  r_tx_valid <= 1'b0;
                  r_pf_valid <= 1'b0;
                  r_pf_last  <= 1'b0;
               end else if (w_issue) begin
                  r_tx_level <= r_pf_level;
                  r_tx_valid <= 1'b1;
                  r_state    <= WAIT;
               end else if (w_finish) begin
                  r_tx_valid <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign sym_addr     = w_fetch_pc;
   assign tim_trig     = w_issue;
   assign tim_duration = w_issue ? r_pf_dur : '0;
   assign tx_level     = r_tx_level;
   assign tx_valid     = r_tx_valid;
   assign busy         = !w_idle;
   assign done_pulse   = w_finish;
   assign loop_pulse   = w_wrap;

endmodule

// File: tb/tb_pulse_transmitter_sequencer.sv
// Directed bench for pulse_transmitter_sequencer with a 2-cycle timer model
// and expected-duration / expected-level queues.
module tb_pulse_transmitter_sequencer;
   import pulse_transmitter_pkg::*;

   localparam int PCW = 7;
   localparam int DW  = 8;
   localparam int LW  = 8;

   // ---------------- clock / reset / DUT ----------------
   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            loop_en = 1'b0;
   logic [LW-1:0]   loop_count = '0;
   logic [PCW-1:0]  prog_start = '0;
   logic [PCW-1:0]  prog_end = '0;
   logic [4*DW-1:0] dur_table = '0;
   logic [PCW-1:0]  sym_addr;
   logic [1:0]      sym_data;
   logic            tim_trig;
   logic [DW-1:0]   tim_duration;
   logic            tim_done;
   logic            tx_level;
   logic            tx_valid;
   logic            busy;
   logic            done_pulse;
   logic            loop_pulse;

   always #5 clk = ~clk;

   pulse_transmitter_sequencer #(
      .PC_WIDTH   (PCW),
      .DUR_WIDTH  (DW),
      .LOOP_WIDTH (LW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .loop_en      (loop_en),
      .loop_count   (loop_count),
      .prog_start   (prog_start),
      .prog_end     (prog_end),
      .dur_table    (dur_table),
      .sym_addr     (sym_addr),
      .sym_data     (sym_data),
      .tim_trig     (tim_trig),
      .tim_duration (tim_duration),
      .tim_done     (tim_done),
      .tx_level     (tx_level),
      .tx_valid     (tx_valid),
      .busy         (busy),
      .done_pulse   (done_pulse),
      .loop_pulse   (loop_pulse)
   );

   // ---------------- symbol memory and timer model ----------------
   logic [1:0] mem [128];
   logic       tmr_done = 1'b0;
   logic       man_done = 1'b0;
   logic       tmr_en = 1'b0;
   logic       chk_en = 1'b0;
   logic       lvl_pend = 1'b0;
   int         tmr_cnt = 0;

   assign sym_data = mem[sym_addr];
   assign tim_done = tmr_done | man_done;

   // ---------------- scoreboard ----------------
   int         n_total = 0;
   int         n_bad = 0;
   int         n_trig = 0;
   int         n_done = 0;
   int         n_loop = 0;
   int         n_tdone = 0;
   logic [DW-1:0] exp_q[$];
   logic          exp_lvl_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Timer responds with tim_done two cycles after each observed trigger.
   initial forever begin
      @(negedge clk);
      if (tmr_en && tmr_cnt == 1) begin
         tmr_done = 1'b1;
         tmr_cnt  = 0;
      end else begin
         tmr_done = 1'b0;
         if (tmr_cnt > 0) tmr_cnt--;
      end
      if (!tmr_en) begin
         tmr_cnt  = 0;
         tmr_done = 1'b0;
      end
      #1;
      if (tim_trig)   n_trig++;
      if (done_pulse) n_done++;
      if (loop_pulse) n_loop++;
      if (tim_done)   n_tdone++;
      if (chk_en && lvl_pend) begin
         check("tx_valid_after_trig", tx_valid, 1);
         check("lvl_q_nonempty", exp_lvl_q.size() != 0, 1);
         if (exp_lvl_q.size() != 0) check("tx_level", tx_level, exp_lvl_q.pop_front());
      end
      lvl_pend = tim_trig;
      if (chk_en && tim_trig) begin
         check("dur_q_nonempty", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) check("tim_duration", tim_duration, exp_q.pop_front());
      end
      if (tmr_en && tim_trig) tmr_cnt = 2;
   end

   // ---------------- driver tasks ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic setup(input logic [PCW-1:0] ps, input logic [PCW-1:0] pe, input logic le,
                        input logic [LW-1:0] lc, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [DW-1:0] d2, input logic [DW-1:0] d3);
      #3;
      prog_start = ps;
      prog_end   = pe;
      loop_en    = le;
      loop_count = lc;
      dur_table  = {d3, d2, d1, d0};
      n_trig = 0; n_done = 0; n_loop = 0; n_tdone = 0;
      lvl_pend = 1'b0;
      exp_q.delete();
      exp_lvl_q.delete();
   endtask

   task automatic expect_sym(input logic [DW-1:0] dur, input logic lvl);
      exp_q.push_back(dur);
      exp_lvl_q.push_back(lvl);
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #2;
         if (n_done != 0) break;
      end
      check({tag, "_finished"}, n_done != 0, 1);
   endtask

   task automatic finish_test();
      start  = 1'b0;
      chk_en = 1'b0;
      tmr_en = 1'b0;
      cycles(4);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      for (int i = 0; i < 128; i++) mem[i] = LOW_A;

      cycles(2); #2;
      check("rst_trig", tim_trig, 0);
      check("rst_dur", tim_duration, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_level", tx_level, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done_pulse, 0);
      check("rst_loop", loop_pulse, 0);
      check("rst_addr", sym_addr, 0);
      @(negedge clk); rst_n = 1'b1;
      cycles(2);

      // 1: four symbols, loop off
      setup(7'd0, 7'd3, 1'b0, 8'd0, 8'd3, 8'd5, 8'd7, 8'd9);
      mem[0] = LOW_A; mem[1] = LOW_B; mem[2] = HIGH_A; mem[3] = HIGH_B;
      expect_sym(8'd3, 1'b0); expect_sym(8'd5, 1'b0);
      expect_sym(8'd7, 1'b1); expect_sym(8'd9, 1'b1);
      tmr_en = 1'b1; chk_en = 1'b1;
      @(negedge clk); start = 1'b1; #2;
      check("t1_no_trig_at_edge", tim_trig, 0);
      check("t1_addr_idle", sym_addr, 0);
      @(negedge clk); #2;
      check("t1_trig_latency", tim_trig, 1);
      check("t1_busy", busy, 1);
      @(negedge clk); #2;
      check("t1_tx_valid_latency", tx_valid, 1);
      wait_done("t1", 100);
      check("t1_trigs", n_trig, 4);
      @(negedge clk); #2;
      check("t1_busy_after", busy, 0);
      check("t1_tx_valid_after", tx_valid, 0);
      check("t1_done_count", n_done, 1);
      check("t1_dur_q_left", exp_q.size(), 0);
      finish_test();

      // 2: two symbols, loop_count=2
      setup(7'd10, 7'd11, 1'b1, 8'd2, 8'd1, 8'd2, 8'd3, 8'd4);
      mem[10] = HIGH_B; mem[11] = LOW_A;
      for (int i = 0; i < 3; i++) begin
         expect_sym(8'd4, 1'b1);
         expect_sym(8'd1, 1'b0);
      end
      tmr_en = 1'b1; chk_en = 1'b1;
      @(negedge clk); start = 1'b1;
      wait_done("t2", 200);
      check("t2_trigs", n_trig, 6);
      check("t2_loops", n_loop, 2);
      @(negedge clk); #2;
      check("t2_done_count", n_done, 1);
      check("t2_busy_after", busy, 0);
      finish_test();

      // 3: infinite loop, 100 timer completions
      setup(7'd20, 7'd21, 1'b1, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4);
      mem[20] = LOW_B; mem[21] = HIGH_A;
      tmr_en = 1'b1;
      @(negedge clk); start = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk); #2;
         if (n_tdone >= 100) break;
      end
      check("t3_tdone_reached", n_tdone, 100);
      check("t3_trigs", n_trig, 101);
      check("t3_loops", n_loop, 51);
      check("t3_no_done", n_done, 0);
      check("t3_busy", busy, 1);
      finish_test();
      check("t3_stop_no_done", n_done, 0);
      check("t3_stop_idle", busy, 0);

      // 4: abort in WAIT colliding with tim_done
      setup(7'd30, 7'd33, 1'b0, 8'd0, 8'd11, 8'd12, 8'd13, 8'd14);
      mem[30] = HIGH_A; mem[31] = LOW_B;
      expect_sym(8'd13, 1'b1);
      chk_en = 1'b1;
      @(negedge clk); start = 1'b1;
      cycles(3);
      start = 1'b0; man_done = 1'b1; #2;
      check("t4_abort_no_trig", tim_trig, 0);
      check("t4_abort_no_done", done_pulse, 0);
      check("t4_abort_no_loop", loop_pulse, 0);
      @(negedge clk); man_done = 1'b0; #2;
      check("t4_tx_valid_off", tx_valid, 0);
      check("t4_busy_off", busy, 0);
      @(negedge clk); man_done = 1'b1; #2;
      check("t4_late_done_trig", tim_trig, 0);
      check("t4_late_done_pulse", done_pulse, 0);
      check("t4_late_done_busy", busy, 0);
      @(negedge clk); man_done = 1'b0; #2;
      check("t4_trigs", n_trig, 1);
      check("t4_done_count", n_done, 0);
      finish_test();

      // 5: window wrapping through index 0
      setup(7'd126, 7'd1, 1'b0, 8'd0, 8'd10, 8'd20, 8'd30, 8'd40);
      mem[126] = HIGH_A; mem[127] = LOW_B; mem[0] = HIGH_B; mem[1] = LOW_A;
      expect_sym(8'd30, 1'b1); expect_sym(8'd20, 1'b0);
      expect_sym(8'd40, 1'b1); expect_sym(8'd10, 1'b0);
      tmr_en = 1'b1; chk_en = 1'b1;
      @(negedge clk); start = 1'b1; #2;
      check("t5_addr_idle", sym_addr, 126);
      wait_done("t5", 100);
      check("t5_trigs", n_trig, 4);
      check("t5_loops", n_loop, 0);
      check("t5_dur_q_left", exp_q.size(), 0);
      finish_test();

      // 6: asynchronous reset mid-WAIT, then clean restart
      setup(7'd40, 7'd41, 1'b0, 8'd0, 8'd6, 8'd7, 8'd8, 8'd9);
      mem[40] = HIGH_B; mem[41] = LOW_A;
      @(negedge clk); start = 1'b1;
      cycles(3); #2;
      check("t6_pre_level", tx_level, 1);
      check("t6_pre_valid", tx_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      check("t6_rst_tx_valid", tx_valid, 0);
      check("t6_rst_tx_level", tx_level, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_trig", tim_trig, 0);
      check("t6_rst_addr", sym_addr, 40);
      start = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      cycles(2);
      setup(7'd40, 7'd41, 1'b0, 8'd0, 8'd6, 8'd7, 8'd8, 8'd9);
      expect_sym(8'd9, 1'b1); expect_sym(8'd6, 1'b0);
      tmr_en = 1'b1; chk_en = 1'b1;
      @(negedge clk); start = 1'b1;
      wait_done("t6", 100);
      check("t6_trigs", n_trig, 2);
      check("t6_dur_q_left", exp_q.size(), 0);
      finish_test();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", n_total, n_bad);
      $fatal(1);
   end

endmodule
